fetch_unit: RTL and testbench

- Instruction fetch stage directly downstream of the program counter register.
- Consumes the registered PC and issues a request to instruction memory with a ready/valid handshake.
- Registers the returned word and the PC it belongs to for the decode stage.
- Computes the next-PC value fed back to the PC register's input (hold, +4, or redirect target), closing the fetch loop.

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_unit_pkg;

    // Fetch sequencer states. At most one memory request is ever in flight.
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,  // free to issue a request for I_pc
        ST_WAIT  = 2'd1,  // request accepted, waiting for its response
        ST_DROP  = 2'd2,  // redirected while waiting; swallow the stale response
        ST_FAULT = 2'd3   // misaligned PC seen; parked until redirected
    } fetch_state_t;

    // Canonical RISC-V NOP (addi x0, x0, 0).
    localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0013;

    // Sequential PC step for 32-bit instructions.
    localparam logic [31:0] PC_INCR = 32'd4;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: issues I_pc to instruction memory, registers the returned word for decode,
// and drives the next-PC value (hold / +4 / redirect) back into the PC register.
// Latency: request accepted in cycle n -> O_valid at n+2 with a single-cycle memory.
// Backpressure: while decode holds an entry (O_valid && !I_ready) no request is issued and the PC holds.
//
// Ports:
//   I_clk, I_rst                  clock, asynchronous active-high reset
//   I_pc / O_next_pc              current PC in, next PC out (closes the loop through the PC register)
//   I_redirect, I_redirect_pc     branch/jump/trap redirect strobe and target
//   O_imem_req/addr, I_imem_ready request side of instruction memory (valid/ready)
//   I_imem_rvalid, I_imem_rdata   response side of instruction memory
//   O_valid/instr/instr_pc/fault  entry presented to decode, consumed with I_ready
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = CPU_NOP_INSTR
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [31:0] I_pc,
    output logic [31:0] O_next_pc,
    input  logic        I_redirect,
    input  logic [31:0] I_redirect_pc,
    output logic        O_imem_req,
    output logic [31:0] O_imem_addr,
    input  logic        I_imem_ready,
    input  logic        I_imem_rvalid,
    input  logic [31:0] I_imem_rdata,
    output logic        O_valid,
    output logic [31:0] O_instr,
    output logic [31:0] O_instr_pc,
    output logic        O_fault,
    input  logic        I_ready
);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic        out_valid_q;
    logic        out_fault_q;
    logic [31:0] out_instr_q;
    logic [31:0] out_pc_q;
    logic [31:0] req_pc_q;      // address of the request currently in flight

    logic        slot_free;
    logic        pc_misal;
    logic        req_raw;
    logic        accept;
    logic        load_mem;
    logic        load_fault;

    // The decode slot can take a new entry if it is empty or being drained this cycle.
    assign slot_free = !out_valid_q || I_ready;
    assign pc_misal  = pc_misaligned(I_pc);

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ: begin
                if (accept) begin
                    state_d = ST_WAIT;
                end else if (pc_misal && slot_free && !I_redirect) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WAIT: begin
                // A response coinciding with a redirect is simply not loaded.
                if (I_imem_rvalid) begin
                    state_d = ST_REQ;
                end else if (I_redirect) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (I_imem_rvalid) begin
                    state_d = ST_REQ;
                end
            end
            ST_FAULT: begin
                if (I_redirect) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    // ---------------------------------------------------------------
    // Output / control decode
    // ---------------------------------------------------------------
    always_comb begin
        req_raw    = 1'b0;
        load_fault = 1'b0;
        load_mem   = 1'b0;
        case (state_q)
            ST_REQ: begin
                req_raw    = slot_free && !I_redirect && !pc_misal;
                load_fault = slot_free && !I_redirect && pc_misal;
            end
            ST_WAIT: begin
                load_mem = I_imem_rvalid && !I_redirect;
            end
            default: begin
                req_raw    = 1'b0;
                load_fault = 1'b0;
                load_mem   = 1'b0;
            end
        endcase
    end

    // Reset gates the request combinationally so it falls the moment reset rises.
    assign O_imem_req  = req_raw && !I_rst;
    assign O_imem_addr = I_pc;
    assign accept      = O_imem_req && I_imem_ready;

    // Next-PC mux lives here so the PC register itself stays a plain flop.
    always_comb begin
        if (I_rst) begin
            O_next_pc = RESET_PC;
        end else if (I_redirect) begin
            O_next_pc = I_redirect_pc;
        end else if (accept) begin
            O_next_pc = I_pc + PC_INCR;
        end else begin
            O_next_pc = I_pc;
        end
    end

    // ---------------------------------------------------------------
    // In-flight request address and decode output register
    // ---------------------------------------------------------------
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            req_pc_q <= 32'h0;
        end else if (accept) begin
            req_pc_q <= I_pc;
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            out_valid_q <= 1'b0;
            out_fault_q <= 1'b0;
            out_instr_q <= NOP_INSTR;
            out_pc_q    <= 32'h0;
        end else if (I_redirect) begin
            // Anything held belongs to the abandoned path.
            out_valid_q <= 1'b0;
            out_fault_q <= 1'b0;
        end else if (load_mem) begin
            out_valid_q <= 1'b1;
            out_fault_q <= 1'b0;
            out_instr_q <= I_imem_rdata;
            out_pc_q    <= req_pc_q;
        end else if (load_fault) begin
            out_valid_q <= 1'b1;
            out_fault_q <= 1'b1;
            out_instr_q <= NOP_INSTR;
            out_pc_q    <= I_pc;
        end else if (I_ready) begin
            out_valid_q <= 1'b0;
            out_fault_q <= 1'b0;
        end
    end

    assign O_valid    = out_valid_q;
    assign O_fault    = out_fault_q;
    assign O_instr    = out_instr_q;
    assign O_instr_pc = out_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: emulates the PC register and an instruction memory, runs directed
// scenarios and a randomized run against a program-order reference of the fetched stream.
// Backpressure on both the memory and the decode side is randomized in the long run.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        I_clk = 1'b0;
    logic        I_rst;
    logic [31:0] I_pc;
    logic [31:0] O_next_pc;
    logic        I_redirect;
    logic [31:0] I_redirect_pc;
    logic        O_imem_req;
    logic [31:0] O_imem_addr;
    logic        I_imem_ready;
    logic        I_imem_rvalid;
    logic [31:0] I_imem_rdata;
    logic        O_valid;
    logic [31:0] O_instr;
    logic [31:0] O_instr_pc;
    logic        O_fault;
    logic        I_ready;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_pc(I_pc), .O_next_pc(O_next_pc),
        .I_redirect(I_redirect), .I_redirect_pc(I_redirect_pc),
        .O_imem_req(O_imem_req), .O_imem_addr(O_imem_addr), .I_imem_ready(I_imem_ready),
        .I_imem_rvalid(I_imem_rvalid), .I_imem_rdata(I_imem_rdata),
        .O_valid(O_valid), .O_instr(O_instr), .O_instr_pc(O_instr_pc), .O_fault(O_fault),
        .I_ready(I_ready)
    );

    always #5 I_clk = ~I_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // memory model knobs/state
    bit          mem_auto = 1'b1;
    int          dly = 1;
    int          spur_pct = 0;
    bit          outst = 1'b0;
    bit          resp_now = 1'b0;
    int          cnt = 0;
    logic [31:0] out_addr = 32'h0;
    bit          fixed_en = 1'b0;
    logic [31:0] fixed_val = 32'h0;

    // samples taken at the falling edge
    logic        s_valid, s_fault, s_req, s_irdy;
    logic [31:0] s_instr, s_ipc, s_addr, s_next, s_pc;

    // program-order reference
    logic [31:0] exp_pc = RESET_PC;
    bit          exp_none = 1'b0;
    int          consumed = 0;
    bit          p_hold = 1'b0;
    logic        p_fault;
    logic [31:0] p_instr, p_ipc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    // One clock cycle: sample and check at negedge, then advance PC register and memory.
    task automatic step();
        logic [31:0] e;
        logic        ef;
        logic [31:0] ei;
        @(negedge I_clk);
        s_valid = O_valid; s_fault = O_fault; s_instr = O_instr; s_ipc = O_instr_pc;
        s_req = O_imem_req; s_addr = O_imem_addr; s_next = O_next_pc;
        s_pc = I_pc; s_irdy = I_imem_ready;
        if (I_rst) begin
            n_cmp++;
            if (s_next !== RESET_PC || s_req !== 1'b0 || s_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL in_reset: next_pc=%h req=%b valid=%b, required %h/0/0", s_next, s_req, s_valid, RESET_PC);
            end
            exp_pc = RESET_PC; exp_none = 1'b0; p_hold = 1'b0;
        end else begin
            n_cmp++;
            if (s_addr !== I_pc) begin
                n_bad++; $display("FAIL imem_addr: got %h, required %h", s_addr, I_pc);
            end
            if (I_redirect) e = I_redirect_pc;
            else if (s_req === 1'b1 && I_imem_ready) e = I_pc + 32'd4;
            else e = I_pc;
            n_cmp++;
            if (s_next !== e) begin
                n_bad++; $display("FAIL next_pc: got %h, required %h", s_next, e);
            end
            if (s_valid === 1'b1 && !I_ready) begin
                n_cmp++;
                if (s_req !== 1'b0) begin
                    n_bad++; $display("FAIL req_while_full: got %b, required 0", s_req);
                end
            end
            if (mem_auto && outst) begin
                n_cmp++;
                if (s_req !== 1'b0) begin
                    n_bad++; $display("FAIL second_outstanding: req=%b, required 0", s_req);
                end
            end
            if (p_hold) begin
                n_cmp++;
                if ({s_valid, s_fault, s_instr, s_ipc} !== {1'b1, p_fault, p_instr, p_ipc}) begin
                    n_bad++;
                    $display("FAIL held_entry: got v=%b f=%b i=%h pc=%h, required v=1 f=%b i=%h pc=%h",
                             s_valid, s_fault, s_instr, s_ipc, p_fault, p_instr, p_ipc);
                end
            end
            p_hold = (s_valid === 1'b1) && !I_ready && !I_redirect;
            p_fault = s_fault; p_instr = s_instr; p_ipc = s_ipc;
            if (s_valid === 1'b1 && I_ready) begin
                n_cmp++;
                consumed++;
                if (exp_none) begin
                    n_bad++; $display("FAIL stray_entry: got pc=%h, required no entry after fault", s_ipc);
                end else begin
                    ef = (exp_pc[1:0] != 2'b00);
                    ei = ef ? NOP : (fixed_en ? fixed_val : mem_word(exp_pc));
                    if ({s_ipc, s_fault, s_instr} !== {exp_pc, ef, ei}) begin
                        n_bad++;
                        $display("FAIL stream: got pc=%h f=%b i=%h, required pc=%h f=%b i=%h",
                                 s_ipc, s_fault, s_instr, exp_pc, ef, ei);
                    end
                    if (ef) exp_none = 1'b1;
                    else exp_pc = exp_pc + 32'd4;
                end
            end
            if (I_redirect) begin
                exp_pc = I_redirect_pc; exp_none = 1'b0;
            end
        end
        @(posedge I_clk);
        #1;
        I_pc = s_next;
        if (mem_auto) begin
            I_imem_rvalid = 1'b0;
            if (resp_now) begin outst = 1'b0; resp_now = 1'b0; end
            if (s_req === 1'b1 && s_irdy) begin
                outst = 1'b1; out_addr = s_addr; cnt = dly;
            end
            if (outst) begin
                cnt--;
                if (cnt == 0) begin
                    I_imem_rvalid = 1'b1;
                    I_imem_rdata  = fixed_en ? fixed_val : mem_word(out_addr);
                    resp_now = 1'b1;
                end
            end else if (spur_pct > 0 && $urandom_range(0, 99) < spur_pct) begin
                I_imem_rvalid = 1'b1;
                I_imem_rdata  = $urandom;
            end
        end
    endtask

    task automatic do_reset();
        I_rst = 1'b1; I_pc = RESET_PC; I_redirect = 1'b0; I_redirect_pc = 32'h0;
        I_imem_rvalid = 1'b0; I_imem_rdata = 32'h0;
        outst = 1'b0; resp_now = 1'b0; mem_auto = 1'b1; spur_pct = 0; fixed_en = 1'b0;
        step(); step();
        I_rst = 1'b0;
    endtask

    task automatic test_reset();
        I_rst = 1'b0; I_pc = 32'hABCD_0000; I_redirect = 1'b0; I_redirect_pc = 32'h0;
        I_imem_ready = 1'b1; I_imem_rvalid = 1'b0; I_imem_rdata = 32'h0; I_ready = 1'b1;
        #2 I_rst = 1'b1;
        #1;
        n_cmp++;
        if ({O_valid, O_fault, O_instr, O_instr_pc} !== {1'b0, 1'b0, NOP, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_entry: got v=%b f=%b i=%h pc=%h, required 0/0/%h/0", O_valid, O_fault, O_instr, O_instr_pc, NOP);
        end
        n_cmp++;
        if (O_imem_req !== 1'b0 || O_next_pc !== RESET_PC) begin
            n_bad++; $display("FAIL reset_req_pc: got req=%b next=%h, required 0/%h", O_imem_req, O_next_pc, RESET_PC);
        end
        do_reset();
    endtask

    task automatic test_first_fetch();
        do_reset();
        I_imem_ready = 1'b1; dly = 1; I_ready = 1'b1; fixed_en = 1'b1; fixed_val = 32'h0050_0093;
        step();
        n_cmp++;
        if (s_req !== 1'b1 || s_next !== 32'h4) begin
            n_bad++; $display("FAIL first_accept: got req=%b next=%h, required 1/00000004", s_req, s_next);
        end
        step();
        n_cmp++;
        if (s_valid !== 1'b0) begin n_bad++; $display("FAIL first_cycle1_valid: got %b, required 0", s_valid); end
        step();
        n_cmp++;
        if ({s_valid, s_instr, s_ipc} !== {1'b1, 32'h0050_0093, 32'h0}) begin
            n_bad++; $display("FAIL first_entry: got v=%b i=%h pc=%h, required 1/00500093/0", s_valid, s_instr, s_ipc);
        end
        fixed_en = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] hi, hp;
        do_reset();
        I_imem_ready = 1'b1; dly = 1; I_ready = 1'b0;
        step(); step(); step();
        n_cmp++;
        if ({s_valid, s_instr, s_ipc} !== {1'b1, mem_word(32'h0), 32'h0}) begin
            n_bad++; $display("FAIL bp_entry: got v=%b i=%h pc=%h, required 1/%h/0", s_valid, s_instr, s_ipc, mem_word(32'h0));
        end
        hi = s_instr; hp = s_ipc;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (s_req !== 1'b0 || s_next !== s_pc || {s_valid, s_instr, s_ipc} !== {1'b1, hi, hp}) begin
                n_bad++;
                $display("FAIL bp_hold: got req=%b next=%h v=%b i=%h pc=%h, required 0/%h/1/%h/%h",
                         s_req, s_next, s_valid, s_instr, s_ipc, s_pc, hi, hp);
            end
        end
        I_ready = 1'b1;
        step();
        n_cmp++;
        if (s_req !== 1'b1) begin n_bad++; $display("FAIL bp_release_req: got %b, required 1", s_req); end
        step();
        n_cmp++;
        if (s_valid !== 1'b0) begin n_bad++; $display("FAIL bp_consumed: got valid=%b, required 0", s_valid); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        I_imem_ready = 1'b1; I_ready = 1'b1; dly = 3;
        step();
        I_redirect = 1'b1; I_redirect_pc = 32'h0000_0100;
        step();
        I_redirect = 1'b0;
        step();
        n_cmp++;
        if (s_valid !== 1'b0 || s_req !== 1'b0) begin
            n_bad++; $display("FAIL rw_drop: got v=%b req=%b, required 0/0", s_valid, s_req);
        end
        dly = 1;
        step();
        n_cmp++;
        if (s_valid !== 1'b0) begin n_bad++; $display("FAIL rw_stale_resp: got valid=%b, required 0", s_valid); end
        step();
        n_cmp++;
        if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h100) begin
            n_bad++; $display("FAIL rw_resume: got v=%b req=%b addr=%h, required 0/1/00000100", s_valid, s_req, s_addr);
        end
        step(); step();
        n_cmp++;
        if ({s_valid, s_ipc, s_instr} !== {1'b1, 32'h100, mem_word(32'h100)}) begin
            n_bad++; $display("FAIL rw_entry: got v=%b pc=%h i=%h, required 1/00000100/%h", s_valid, s_ipc, s_instr, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_same();
        do_reset();
        I_imem_ready = 1'b1; I_ready = 1'b1; dly = 2;
        step(); step();
        I_redirect = 1'b1; I_redirect_pc = 32'h0000_0300;
        step();
        I_redirect = 1'b0; dly = 1;
        step();
        n_cmp++;
        if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h300) begin
            n_bad++; $display("FAIL rs_resume: got v=%b req=%b addr=%h, required 0/1/00000300", s_valid, s_req, s_addr);
        end
        step(); step();
        n_cmp++;
        if ({s_valid, s_ipc} !== {1'b1, 32'h300}) begin
            n_bad++; $display("FAIL rs_entry: got v=%b pc=%h, required 1/00000300", s_valid, s_ipc);
        end
    endtask

    task automatic test_fault();
        do_reset();
        I_imem_ready = 1'b1; I_ready = 1'b0; dly = 1;
        I_redirect = 1'b1; I_redirect_pc = 32'h0000_0102;
        step();
        I_redirect = 1'b0;
        step();
        n_cmp++;
        if (s_req !== 1'b0) begin n_bad++; $display("FAIL fault_no_req: got %b, required 0", s_req); end
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if ({s_valid, s_fault, s_instr, s_ipc, s_req} !== {1'b1, 1'b1, NOP, 32'h102, 1'b0}) begin
                n_bad++;
                $display("FAIL fault_entry: got v=%b f=%b i=%h pc=%h req=%b, required 1/1/%h/00000102/0",
                         s_valid, s_fault, s_instr, s_ipc, s_req, NOP);
            end
        end
        I_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i > 0) begin
                n_cmp++;
                if (s_valid !== 1'b0 || s_req !== 1'b0) begin
                    n_bad++; $display("FAIL fault_parked: got v=%b req=%b, required 0/0", s_valid, s_req);
                end
            end
        end
        I_redirect = 1'b1; I_redirect_pc = 32'h0000_0200;
        step();
        I_redirect = 1'b0;
        step();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'h200) begin
            n_bad++; $display("FAIL fault_resume: got req=%b addr=%h, required 1/00000200", s_req, s_addr);
        end
        step(); step();
    endtask

    task automatic test_wrap();
        do_reset();
        I_imem_ready = 1'b1; I_ready = 1'b1; dly = 1;
        I_redirect = 1'b1; I_redirect_pc = 32'hFFFF_FFFC;
        step();
        I_redirect = 1'b0;
        step();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC || s_next !== 32'h0) begin
            n_bad++; $display("FAIL wrap_next: got req=%b addr=%h next=%h, required 1/fffffffc/00000000", s_req, s_addr, s_next);
        end
        step(); step();
        n_cmp++;
        if ({s_valid, s_ipc, s_req, s_addr} !== {1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0}) begin
            n_bad++; $display("FAIL wrap_entry: got v=%b pc=%h req=%b addr=%h, required 1/fffffffc/1/0", s_valid, s_ipc, s_req, s_addr);
        end
    endtask

    task automatic test_async_reset();
        // entry held, then reset mid-cycle
        do_reset();
        I_imem_ready = 1'b1; I_ready = 1'b0; dly = 1;
        step(); step(); step();
        #2 I_rst = 1'b1; I_pc = RESET_PC;
        #1;
        n_cmp++;
        if (O_valid !== 1'b0 || O_fault !== 1'b0 || O_instr !== NOP) begin
            n_bad++; $display("FAIL async_valid: got v=%b f=%b i=%h, required 0/0/%h", O_valid, O_fault, O_instr, NOP);
        end
        outst = 1'b0; resp_now = 1'b0;
        step(); I_rst = 1'b0;
        // request pending (memory stalling), then reset mid-cycle
        mem_auto = 1'b0; I_imem_ready = 1'b0; I_ready = 1'b1;
        #2;
        n_cmp++;
        if (O_imem_req !== 1'b1) begin n_bad++; $display("FAIL async_pre_req: got %b, required 1", O_imem_req); end
        I_rst = 1'b1; I_pc = RESET_PC;
        #1;
        n_cmp++;
        if (O_imem_req !== 1'b0 || O_next_pc !== RESET_PC) begin
            n_bad++; $display("FAIL async_req: got req=%b next=%h, required 0/%h", O_imem_req, O_next_pc, RESET_PC);
        end
        step(); I_rst = 1'b0;
        // request accepted, reset while waiting, response arrives late
        I_imem_ready = 1'b1;
        step();
        #2 I_rst = 1'b1; I_pc = RESET_PC;
        #1;
        n_cmp++;
        if (O_imem_req !== 1'b0 || O_valid !== 1'b0) begin
            n_bad++; $display("FAIL async_wait: got req=%b v=%b, required 0/0", O_imem_req, O_valid);
        end
        step(); I_rst = 1'b0;
        I_imem_ready = 1'b0; I_imem_rvalid = 1'b1; I_imem_rdata = 32'hDEAD_BEEF;
        step();
        I_imem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (s_valid !== 1'b0) begin n_bad++; $display("FAIL late_rvalid: got valid=%b, required 0", s_valid); end
        end
        mem_auto = 1'b1; outst = 1'b0; resp_now = 1'b0; I_imem_ready = 1'b1; dly = 1;
        step(); step(); step();
        n_cmp++;
        if ({s_valid, s_ipc, s_instr} !== {1'b1, 32'h0, mem_word(32'h0)}) begin
            n_bad++; $display("FAIL async_recover: got v=%b pc=%h i=%h, required 1/0/%h", s_valid, s_ipc, s_instr, mem_word(32'h0));
        end
    endtask

    task automatic test_random();
        int c0;
        do_reset();
        spur_pct = 10;
        c0 = consumed;
        for (int i = 0; i < 3000; i++) begin
            step();
            I_ready      = ($urandom_range(0, 99) < 70);
            I_imem_ready = ($urandom_range(0, 99) < 60);
            dly          = $urandom_range(1, 3);
            if ($urandom_range(0, 99) < 4) begin
                I_redirect = 1'b1;
                if ($urandom_range(0, 15) == 0) I_redirect_pc = 32'hFFFF_FFF0;
                else I_redirect_pc = ($urandom & 32'h0000_0FFC) | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
            end else begin
                I_redirect = 1'b0;
            end
        end
        I_redirect = 1'b0;
        n_cmp++;
        if (consumed - c0 < 100) begin
            n_bad++; $display("FAIL random_progress: got %0d entries, required at least 100", consumed - c0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect_wait();
        test_redirect_same();
        test_fault();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
